// File: rtl/data_master.sv
// data_master: upstream producer for the valid/ready data link.
// Words from a local source are buffered in a small circular FIFO and offered
// one at a time on data/valid using a full four-phase handshake: the word is
// held until ready rises, then valid drops and the master waits for ready to
// fall before offering the next word.
// Optional feature: define DATA_MASTER_TIMEOUT_EN to abandon a word that sees
// no ready for TIMEOUT cycles (err_timeout pulses once when that happens).
module data_master #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         data,
   output logic                     valid,
   input  logic                     ready,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_LOW
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   logic             w_push;
   logic             w_pop;
   logic             w_empty;

`ifdef DATA_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]    r_tmo;
   logic [TW-1:0]    w_tmoNext;
   logic             w_tmoHit;
   logic             r_errTimeout;

   // The word is abandoned on the edge that completes TIMEOUT cycles in SEND
   assign w_tmoNext   = r_tmo + TW'(1);
   assign w_tmoHit    = (w_tmoNext == TW'(TIMEOUT));
   assign err_timeout = r_errTimeout;
`else
   assign err_timeout = 1'b0;
`endif

   // A pop only ever happens together with a transition into SEND
   assign w_empty    = (r_count == '0);
   assign in_ready   = (r_count != CW'(DEPTH));
   assign w_push     = in_valid && in_ready;
   assign w_pop      = !w_empty && ((r_state == IDLE) ||
                                    ((r_state == WAIT_LOW) && !ready));
   assign busy       = (r_state != IDLE) || !w_empty;
   assign fifo_count = r_count;
   assign data       = r_data;
   assign valid      = r_valid;

   // FIFO storage; contents are meaningless until pushed, so no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= in_data;
      end
   end

   // FIFO pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Handshake state machine with registered data/valid outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_valid <= 1'b0;
`ifdef DATA_MASTER_TIMEOUT_EN
         r_tmo        <= '0;
         r_errTimeout <= 1'b0;
`endif
      end else begin
`ifdef DATA_MASTER_TIMEOUT_EN
         r_errTimeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               r_valid <= 1'b0;
               if (!w_empty) begin
                  r_data  <= r_mem[r_rdPtr];
                  r_valid <= 1'b1;
                  r_state <= SEND;
`ifdef DATA_MASTER_TIMEOUT_EN
                  r_tmo   <= '0;
`endif
               end
            end
            SEND: begin
               if (ready) begin
                  r_valid <= 1'b0;
                  r_state <= WAIT_LOW;
               end
`ifdef DATA_MASTER_TIMEOUT_EN
               else if (w_tmoHit) begin
                  r_valid      <= 1'b0;
                  r_errTimeout <= 1'b1;
                  r_state      <= WAIT_LOW;
               end else begin
                  r_tmo <= w_tmoNext;
               end
`endif
            end
            WAIT_LOW: begin
               r_valid <= 1'b0;
               if (!ready) begin
                  if (!w_empty) begin
                     r_data  <= r_mem[r_rdPtr];
                     r_valid <= 1'b1;
                     r_state <= SEND;
`ifdef DATA_MASTER_TIMEOUT_EN
                     r_tmo   <= '0;
`endif
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/data_master.md
# data_master

Upstream producer for the valid/ready data link. The block buffers words from a local source in a small FIFO and presents them one at a time on `data`/`valid`. It holds each word stable until the downstream slave returns `ready`, then waits for `ready` to fall before offering the next word. This makes every transfer a full four-phase handshake, which the registered-valid slave requires.

## Interface
- WIDTH, 4, data word width in bits.
- DEPTH, 4, FIFO depth in words; power of 2, ≥2.
- TIMEOUT, 15, cycles in SEND without `ready` before the word is abandoned (only with the timeout macro).

- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  WIDTH  word from local source.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO not full; a push occurs on a rising edge where in_valid && in_ready.
- data  output  WIDTH  word to slave; registered; stable for the whole of SEND.
- valid  output  1  to slave; registered.
- ready  input  1  from slave; level, sampled on clk.
- busy  output  1  high when state ≠ IDLE or the FIFO is non-empty.
- fifo_count  output  $clog2(DEPTH)+1  number of words buffered.
- err_timeout  output  1  one-cycle pulse when a word is abandoned.

## Operation
- Reset values:
  - data=0, valid=0, err_timeout=0, fifo_count=0.
  - in_ready=1, busy=0, state=IDLE.
  - FIFO pointers=0; buffered words are discarded.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - fifo_count is a separate counter: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - Push is ignored when full (in_ready=0). Pop occurs only on the state transition into SEND.
- State machine, 3 states:
  - IDLE: valid=0. If FIFO non-empty, pop the head into the data register, set valid=1, go to SEND.
  - SEND: valid=1, data held.
    - If ready=1: valid←0, go to WAIT_LOW.
    - Timeout (macro on): go to WAIT_LOW.
  - WAIT_LOW: valid=0; waits for ready=0 so a stale `ready` is never taken as an acknowledgement of the next word.
    - On ready=0 with FIFO non-empty: pop and go directly to SEND.
    - On ready=0 with FIFO empty: go to IDLE.
- The data register keeps its last value when valid=0; it is not cleared.
- A ready=1 seen in IDLE is ignored.

## Timing
- Push at edge n into an empty FIFO with state IDLE: valid=1 and data=word after edge n+1.
- Paired with the slave (valid registered once, ready/capture one cycle later):
  - ready=1 after edge n+3; master drops valid at edge n+4.
  - ready=0 after edge n+6; next word presented at edge n+7.
  - Steady-state throughput: 1 word per 6 cycles; valid is high for 3 cycles per word.
- Ready in SEND is acted on at the first edge that samples it high; there is no combinational path from ready to valid.
- in_ready = (fifo_count≠DEPTH), combinational from the registered count.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). The in-flight word and buffered words are lost. Any ready still high from the slave is absorbed by the IDLE rule above.

## Configuration
- DATA_MASTER_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT+1) bits clears on entry to SEND and increments each cycle in SEND without ready.
  - When it equals TIMEOUT and ready=0: valid←0, err_timeout=1 for one cycle, word dropped (not re-queued), go to WAIT_LOW.
  - ready=1 on the same edge as the timeout wins; it is a normal transfer with no error.
- Not defined:
  - No counter. SEND waits indefinitely; err_timeout is tied to 0.

## Test plan
- Single word: push 4'hA at edge 0 with the slave model attached -> valid rises after edge 1 with data=4'hA; slave data_out=4'hA; valid falls after edge 4; busy=0 after edge 7.
- Burst/full: push 4'h1..4'h5 back-to-back with DEPTH=4 -> in_ready=0 once fifo_count=4; slave receives 1,2,3,4 in order with the valid rising edges 6 cycles apart; wrap-around is exercised.
- Simultaneous push and pop: push on the same edge the FIFO pops (IDLE→SEND) with fifo_count=2 -> fifo_count stays at 2.
- Stale ready: hold ready=1 externally for 10 cycles after the first acknowledgement -> master stays in WAIT_LOW with valid=0; second word is presented the edge after ready falls.
- Timeout (macro on, TIMEOUT=15): ready tied 0, push 4'h7 -> valid stays high for 15 cycles, then valid=0 and err_timeout high for 1 cycle; the word is not re-sent. With the macro off, valid stays high indefinitely and err_timeout stays 0.
- Reset mid-SEND: assert rst_n=0 with 3 words buffered and valid=1 -> valid=0, fifo_count=0, in_ready=1 without waiting for a clock edge.
